// File: rtl/pipe_hazard_unit.sv
// Pipeline hazard unit: tracks in-flight destinations after decode, selects forwarding
// sources, detects load-use hazards, and counts stall/flush cycles.
module pipe_hazard_unit #(
  parameter int DEPTH      = 3,
  parameter int REG_AW     = 5,
  parameter int LOAD_READY = 2,
  parameter int CNT_W      = 16,
  localparam int SEL_W     = $clog2(DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              d_valid,
  input  logic [REG_AW-1:0] d_rs1,
  input  logic [REG_AW-1:0] d_rs2,
  input  logic              d_use_rs1,
  input  logic              d_use_rs2,
  input  logic [REG_AW-1:0] d_rd,
  input  logic              d_wen,
  input  logic              d_is_load,
  input  logic              e_brn_tkn,
  output logic              stall,
  output logic              flush,
  output logic [SEL_W-1:0]  fwd_sel_rs1,
  output logic [SEL_W-1:0]  fwd_sel_rs2,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  // Tracker entry i mirrors the instruction currently in stage i (1 = execute).
  logic [REG_AW-1:0] rd_q   [1:DEPTH];
  logic              wen_q  [1:DEPTH];
  logic              load_q [1:DEPTH];

  logic hazard_rs1;
  logic hazard_rs2;

  // Scanning oldest-to-youngest lets the youngest writer overwrite older matches.
  always_comb begin
    fwd_sel_rs1 = '0;
    fwd_sel_rs2 = '0;
    hazard_rs1  = 1'b0;
    hazard_rs2  = 1'b0;
    for (int i = DEPTH; i >= 1; i--) begin
      if (d_use_rs1 && wen_q[i] && (rd_q[i] == d_rs1) && (d_rs1 != '0)) begin
        fwd_sel_rs1 = SEL_W'(i);
        hazard_rs1  = load_q[i] && (i < LOAD_READY);
      end
      if (d_use_rs2 && wen_q[i] && (rd_q[i] == d_rs2) && (d_rs2 != '0)) begin
        fwd_sel_rs2 = SEL_W'(i);
        hazard_rs2  = load_q[i] && (i < LOAD_READY);
      end
    end
    flush = e_brn_tkn;
    stall = d_valid && (hazard_rs1 || hazard_rs2) && !e_brn_tkn;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 1; i <= DEPTH; i++) begin
        rd_q[i]   <= '0;
        wen_q[i]  <= 1'b0;
        load_q[i] <= 1'b0;
      end
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      for (int i = DEPTH; i >= 2; i--) begin
        rd_q[i]   <= rd_q[i-1];
        wen_q[i]  <= wen_q[i-1];
        load_q[i] <= load_q[i-1];
      end
      // A stalled or squashed decode instruction must not enter execute.
      if (d_valid && !stall && !flush) begin
        rd_q[1]   <= d_rd;
        wen_q[1]  <= d_wen;
        load_q[1] <= d_is_load;
      end else begin
        rd_q[1]   <= '0;
        wen_q[1]  <= 1'b0;
        load_q[1] <= 1'b0;
      end
      if (stall && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush && (flush_cnt != {CNT_W{1'b1}}))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Bench for pipe_hazard_unit: directed vector table, randomized run against a queue model,
// and counter saturation / reset-during-stall sequences on a default and a narrow-counter instance.
module tb_pipe_hazard_unit;
  localparam int LR        = 2;
  localparam int BIG_MAX   = 65535;
  localparam int SMALL_W   = 6;
  localparam int SMALL_MAX = 63;

  logic       clock;
  logic       reset;
  logic       d_valid;
  logic [4:0] d_rs1, d_rs2, d_rd;
  logic       d_use_rs1, d_use_rs2, d_wen, d_is_load, e_brn_tkn;

  logic         stall_b, flush_b, stall_s, flush_s;
  logic [1:0]   s1_b, s2_b, s1_s, s2_s;
  logic [15:0]  sc_b, fc_b;
  logic [SMALL_W-1:0] sc_s, fc_s;

  pipe_hazard_unit dut (
    .clock(clock), .reset(reset), .d_valid(d_valid), .d_rs1(d_rs1), .d_rs2(d_rs2),
    .d_use_rs1(d_use_rs1), .d_use_rs2(d_use_rs2), .d_rd(d_rd), .d_wen(d_wen),
    .d_is_load(d_is_load), .e_brn_tkn(e_brn_tkn), .stall(stall_b), .flush(flush_b),
    .fwd_sel_rs1(s1_b), .fwd_sel_rs2(s2_b), .stall_cnt(sc_b), .flush_cnt(fc_b)
  );

  pipe_hazard_unit #(.CNT_W(SMALL_W)) dut_small (
    .clock(clock), .reset(reset), .d_valid(d_valid), .d_rs1(d_rs1), .d_rs2(d_rs2),
    .d_use_rs1(d_use_rs1), .d_use_rs2(d_use_rs2), .d_rd(d_rd), .d_wen(d_wen),
    .d_is_load(d_is_load), .e_brn_tkn(e_brn_tkn), .stall(stall_s), .flush(flush_s),
    .fwd_sel_rs1(s1_s), .fwd_sel_rs2(s2_s), .stall_cnt(sc_s), .flush_cnt(fc_s)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       rst, v;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       wen, ld, brn;
    int         e_stall, e_flush, e_s1, e_s2, e_sc, e_fc;
  } vec_t;

  typedef struct {
    logic [4:0] rd;
    logic       wen, ld;
  } ent_t;

  // Reference model: trk[0] is the youngest in-flight instruction (stage 1).
  ent_t trk[$];
  int   m_sc_b, m_fc_b, m_sc_s, m_fc_s;
  int   checks = 0;
  int   errors = 0;
  vec_t tab[$];

  function automatic vec_t mk(logic rst, logic v, logic [4:0] rs1, logic u1, logic [4:0] rs2,
                              logic u2, logic [4:0] rd, logic wen, logic ld, logic brn,
                              int e_stall, int e_flush, int e_s1, int e_s2, int e_sc, int e_fc);
    vec_t x;
    x.rst = rst; x.v = v; x.rs1 = rs1; x.u1 = u1; x.rs2 = rs2; x.u2 = u2;
    x.rd = rd; x.wen = wen; x.ld = ld; x.brn = brn;
    x.e_stall = e_stall; x.e_flush = e_flush; x.e_s1 = e_s1; x.e_s2 = e_s2;
    x.e_sc = e_sc; x.e_fc = e_fc;
    return x;
  endfunction

  function automatic int youngest(logic [4:0] s, logic u);
    if (!u || s == 5'd0) return 0;
    foreach (trk[k]) if (trk[k].wen && trk[k].rd == s) return k + 1;
    return 0;
  endfunction

  function automatic int sat_inc(int v, int lim);
    return (v < lim) ? v + 1 : lim;
  endfunction

  function automatic void model_reset();
    ent_t bub;
    bub.rd = '0; bub.wen = 1'b0; bub.ld = 1'b0;
    trk = {bub, bub, bub};
    m_sc_b = 0; m_fc_b = 0; m_sc_s = 0; m_fc_s = 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Driver: one cycle. mode 0 = no checks, 1 = table expectations, 2 = model expectations.
  task automatic step(input vec_t x, input int mode);
    int   s1, s2, es, ef, es1, es2, esc_b, efc_b, esc_s, efc_s;
    logic haz, m_stall, m_flush;
    ent_t e;
    @(negedge clock);
    reset = x.rst; d_valid = x.v; d_rs1 = x.rs1; d_use_rs1 = x.u1; d_rs2 = x.rs2;
    d_use_rs2 = x.u2; d_rd = x.rd; d_wen = x.wen; d_is_load = x.ld; e_brn_tkn = x.brn;
    #1;
    s1  = youngest(x.rs1, x.u1);
    s2  = youngest(x.rs2, x.u2);
    haz = (s1 > 0 && s1 < LR && trk[s1-1].ld) || (s2 > 0 && s2 < LR && trk[s2-1].ld);
    m_stall = x.v && haz && !x.brn;
    m_flush = x.brn;
    if (mode == 1) begin
      es = x.e_stall; ef = x.e_flush; es1 = x.e_s1; es2 = x.e_s2;
      esc_b = x.e_sc; efc_b = x.e_fc; esc_s = x.e_sc; efc_s = x.e_fc;
    end else begin
      es = int'(m_stall); ef = int'(m_flush); es1 = s1; es2 = s2;
      esc_b = m_sc_b; efc_b = m_fc_b; esc_s = m_sc_s; efc_s = m_fc_s;
    end
    if (mode != 0) begin
      chk("stall", 32'(stall_b), 32'(es));
      chk("flush", 32'(flush_b), 32'(ef));
      chk("fwd_sel_rs1", 32'(s1_b), 32'(es1));
      chk("fwd_sel_rs2", 32'(s2_b), 32'(es2));
      chk("stall_cnt", 32'(sc_b), 32'(esc_b));
      chk("flush_cnt", 32'(fc_b), 32'(efc_b));
      chk("small_stall", 32'(stall_s), 32'(es));
      chk("small_flush", 32'(flush_s), 32'(ef));
      chk("small_fwd_sel_rs1", 32'(s1_s), 32'(es1));
      chk("small_fwd_sel_rs2", 32'(s2_s), 32'(es2));
      chk("small_stall_cnt", 32'(sc_s), 32'(esc_s));
      chk("small_flush_cnt", 32'(fc_s), 32'(efc_s));
    end
    @(posedge clock);
    if (x.rst) begin
      model_reset();
    end else begin
      if (m_stall) begin m_sc_b = sat_inc(m_sc_b, BIG_MAX); m_sc_s = sat_inc(m_sc_s, SMALL_MAX); end
      if (m_flush) begin m_fc_b = sat_inc(m_fc_b, BIG_MAX); m_fc_s = sat_inc(m_fc_s, SMALL_MAX); end
      e.rd = '0; e.wen = 1'b0; e.ld = 1'b0;
      if (x.v && !m_stall && !m_flush) begin e.rd = x.rd; e.wen = x.wen; e.ld = x.ld; end
      void'(trk.pop_back());
      trk.push_front(e);
    end
  endtask

  initial begin
    vec_t x;
    model_reset();
    reset = 1'b1; d_valid = 0; d_rs1 = 0; d_rs2 = 0; d_use_rs1 = 0; d_use_rs2 = 0;
    d_rd = 0; d_wen = 0; d_is_load = 0; e_brn_tkn = 0;

    //          rst v rs1 u1 rs2 u2 rd wen ld brn | stall flush s1 s2 sc fc
    tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0)); // idle after reset
    tab.push_back(mk(0, 1, 0, 0, 0, 0, 5, 1, 0, 0,   0, 0, 0, 0, 0, 0)); // add x5
    tab.push_back(mk(0, 1, 5, 1, 0, 0, 0, 0, 0, 0,   0, 0, 1, 0, 0, 0)); // read x5 -> stage 1
    tab.push_back(mk(0, 1, 5, 1, 0, 0, 0, 0, 0, 0,   0, 0, 2, 0, 0, 0)); // -> stage 2
    tab.push_back(mk(0, 1, 5, 1, 0, 0, 0, 0, 0, 0,   0, 0, 3, 0, 0, 0)); // -> stage 3
    tab.push_back(mk(0, 1, 0, 0, 0, 0, 7, 1, 1, 0,   0, 0, 0, 0, 0, 0)); // load x7
    tab.push_back(mk(0, 1, 0, 0, 7, 1, 0, 0, 0, 0,   1, 0, 0, 1, 0, 0)); // load-use stall
    tab.push_back(mk(0, 1, 0, 0, 7, 1, 0, 0, 0, 0,   0, 0, 0, 2, 1, 0)); // released, fwd 2
    tab.push_back(mk(0, 1, 0, 0, 0, 0, 3, 1, 0, 0,   0, 0, 0, 0, 1, 0)); // writer x3
    tab.push_back(mk(0, 1, 3, 1, 0, 0, 3, 1, 0, 0,   0, 0, 1, 0, 1, 0)); // writer x3, reads x3
    tab.push_back(mk(0, 1, 3, 1, 0, 1, 0, 1, 0, 0,   0, 0, 1, 0, 1, 0)); // x3 in 1 and 2 -> 1
    tab.push_back(mk(0, 1, 0, 1, 3, 1, 0, 0, 0, 0,   0, 0, 0, 2, 1, 0)); // x0 writer never matches
    tab.push_back(mk(0, 1, 0, 0, 0, 0, 9, 1, 1, 0,   0, 0, 0, 0, 1, 0)); // load x9
    tab.push_back(mk(0, 1, 9, 1, 0, 0, 4, 1, 0, 1,   0, 1, 1, 0, 1, 0)); // hazard + branch
    tab.push_back(mk(0, 1, 9, 1, 4, 1, 0, 0, 0, 0,   0, 0, 2, 0, 1, 1)); // squashed x4 absent
    tab.push_back(mk(0, 1, 0, 0, 0, 0, 6, 1, 1, 0,   0, 0, 0, 0, 1, 1)); // load x6
    tab.push_back(mk(0, 0, 6, 1, 0, 0, 0, 0, 0, 0,   0, 0, 1, 0, 1, 1)); // no stall if invalid
    tab.push_back(mk(0, 1, 6, 1, 0, 0, 0, 0, 0, 0,   0, 0, 2, 0, 1, 1));
    tab.push_back(mk(0, 1, 0, 0, 0, 0, 8, 1, 1, 0,   0, 0, 0, 0, 1, 1)); // load x8
    tab.push_back(mk(1, 1, 8, 1, 0, 0, 0, 0, 0, 0,   1, 0, 1, 0, 1, 1)); // stall with reset
    tab.push_back(mk(0, 1, 8, 1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0)); // stall cleared

    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0);
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0);
    for (int i = 0; i < tab.size(); i++) step(tab[i], 1);

    // Randomized run against the model.
    for (int n = 0; n < 3000; n++) begin
      x = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      x.rst = ($urandom_range(0, 99) == 0);
      x.v   = ($urandom_range(0, 3) != 0);
      x.rs1 = 5'($urandom_range(0, 7));
      x.rs2 = 5'($urandom_range(0, 7));
      x.rd  = 5'($urandom_range(0, 7));
      x.u1  = 1'($urandom_range(0, 1));
      x.u2  = 1'($urandom_range(0, 1));
      x.wen = ($urandom_range(0, 3) != 0);
      x.ld  = ($urandom_range(0, 2) == 0);
      x.brn = ($urandom_range(0, 9) == 0);
      step(x, 2);
    end

    // 70 load-use stalls: narrow counter saturates, wide one keeps counting.
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 2);
    for (int n = 0; n < 70; n++) begin
      step(mk(0, 1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0, 0, 0, 0, 0), 2);
      step(mk(0, 1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 2);
    end
    #2;
    chk("sat_small_stall_cnt", 32'(sc_s), SMALL_MAX);
    chk("wide_stall_cnt_70", 32'(sc_b), 70);

    // Reset while stalling clears stall and counters on the next cycle.
    step(mk(0, 1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0, 0, 0, 0, 0), 2);
    step(mk(1, 1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 2);
    #2;
    chk("stall_after_reset", 32'(stall_b), 0);
    chk("stall_cnt_after_reset", 32'(sc_b), 0);
    chk("small_stall_cnt_after_reset", 32'(sc_s), 0);

    // 70 taken branches: flush counter saturation.
    for (int n = 0; n < 70; n++)
      step(mk(0, 1, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0), 2);
    #2;
    chk("sat_small_flush_cnt", 32'(fc_s), SMALL_MAX);
    chk("wide_flush_cnt_70", 32'(fc_b), 70);
    chk("stall_cnt_flush_only", 32'(sc_b), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_unit.md
PIPE_HAZARD_UNIT -- requirements
Module: pipe_hazard_unit

Interface
REQ-001 Parameter DEPTH, default 3, is the number of tracked stages after decode (1=execute ... DEPTH=writeback); legal range 2..6.
REQ-002 Parameter REG_AW, default 5, is the register-address width.
REQ-003 Parameter LOAD_READY, default 2, is the first stage index at which load data is forwardable; legal range 1..DEPTH.
REQ-004 Parameter CNT_W, default 16, is the width of the performance counters.
REQ-005 Port clock  input  1  is the single clock; all state updates on its rising edge.
REQ-006 Port reset  input  1  is the synchronous, active-high reset.
REQ-007 Port d_valid  input  1  means the decode stage holds a real instruction.
REQ-008 Ports d_rs1, d_rs2  input  REG_AW each  are the decode source register addresses.
REQ-009 Ports d_use_rs1, d_use_rs2  input  1 each  mean the decode instruction reads that source.
REQ-010 Ports d_rd  input  REG_AW  and d_wen  input  1  are the decode destination and write-back enable.
REQ-011 Port d_is_load  input  1  marks the decode instruction as a load.
REQ-012 Port e_brn_tkn  input  1  means the execute-stage instruction redirects the PC this cycle.
REQ-013 Port stall  output  1  holds the PC and fetch/decode registers.
REQ-014 Port flush  output  1  squashes the fetch and decode instructions.
REQ-015 Ports fwd_sel_rs1, fwd_sel_rs2  output  clog2(DEPTH+1) each  give the forwarding source stage index (0 = register file).
REQ-016 Ports stall_cnt, flush_cnt  output  CNT_W each  are saturating event counters.

Function
REQ-017 The block SHALL keep a tracker entry per stage i in 1..DEPTH holding rd[i], wen[i], load[i].
REQ-018 Each cycle, entries i=2..DEPTH SHALL load from entry i-1, and entry DEPTH's old contents SHALL retire.
REQ-019 Entry 1 SHALL load the decode fields when d_valid=1 and stall=0 and flush=0; otherwise it SHALL load a bubble (wen=0, load=0, rd=0).
REQ-020 A tracker entry SHALL match source s when wen[i]=1, rd[i]==s and s!=0; register x0 never matches.
REQ-021 fwd_sel_rsN SHALL equal the smallest matching i (youngest writer) when d_use_rsN=1, else 0; combinational from state and inputs, zero latency.
REQ-022 A load-use hazard exists when, for a used source, the youngest match has load[i]=1 and i < LOAD_READY.
REQ-023 stall SHALL be 1 exactly when d_valid=1, a load-use hazard exists and e_brn_tkn=0.
REQ-024 flush SHALL equal e_brn_tkn; flush SHALL have priority over stall in the same cycle (stall forced to 0).
REQ-025 A stall SHALL last until the load reaches stage LOAD_READY: LOAD_READY-i consecutive cycles for a load in stage i.
REQ-026 stall_cnt SHALL increment by 1 each cycle stall=1 and flush_cnt each cycle flush=1; each SHALL hold at 2^CNT_W-1 once reached (no wrap).
REQ-027 When stall=1, fwd_sel values SHALL still reflect the current tracker contents.

Reset
REQ-028 While reset=1 on a rising edge, all tracker entries SHALL become bubbles and both counters SHALL become 0.
REQ-029 Consequently stall, flush (when e_brn_tkn=0) and both fwd_sel outputs SHALL read 0 in the cycle after reset.
REQ-030 Reset asserted mid-stall SHALL clear the stall on the next cycle regardless of decode inputs.

Verification (DEPTH=3, LOAD_READY=2, CNT_W=16)
REQ-031 Reset then idle inputs -> stall=0, flush=0, fwd_sel_rs1=fwd_sel_rs2=0, counters=0.
REQ-032 Issue add x5 (d_wen=1), next cycle decode reads rs1=x5 -> fwd_sel_rs1=1, stall=0; one cycle later (new instruction reads x5) -> fwd_sel_rs1=2.
REQ-033 Issue load x7, next cycle decode reads rs2=x7 -> stall=1 for exactly one cycle, stall_cnt=1, then fwd_sel_rs2=2 with stall=0.
REQ-034 Writers to x3 in stages 1 and 2, decode reads x3 -> fwd_sel_rs1=1; writer to x0 in stage 1, decode reads x0 -> fwd_sel_rs1=0.
REQ-035 Load-use hazard present and e_brn_tkn=1 same cycle -> flush=1, stall=0, entry 1 becomes bubble, flush_cnt=1, stall_cnt unchanged.
REQ-036 Force a hazard for 70000 cycles -> stall_cnt saturates at 65535; reset asserted during the stall -> stall=0 and stall_cnt=0 next cycle.
